// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI4-Lite response codes and FSM state types for the register file slave.
package axil_pkg;
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;
endpackage

// File: rtl/axil_wstrb_merge.sv
// axil_wstrb_merge: byte-strobe merge of old and new words; strobes honoured only with
// AXIL_REGFILE_WSTRB_EN defined, otherwise the new word passes straight through.
module axil_wstrb_merge #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_i,
    input  logic [DATA_W-1:0]   new_i,
    input  logic [DATA_W/8-1:0] strb_i,
    output logic [DATA_W-1:0]   merged_o
);
`ifdef AXIL_REGFILE_WSTRB_EN
    always_comb begin
        merged_o = old_i;
        for (int b = 0; b < DATA_W/8; b++)
            merged_o[b*8 +: 8] = strb_i[b] ? new_i[b*8 +: 8] : old_i[b*8 +: 8];
    end
`else
    logic unused_merge;
    assign unused_merge = ^{old_i, strb_i};
    assign merged_o     = new_i;
`endif
endmodule

// File: rtl/axi4_lite_regfile_slave.sv
// axi4_lite_regfile_slave: parametrised AXI4-Lite register file with DECERR decode,
// AW/W in either order and optional byte strobes (AXIL_REGFILE_WSTRB_EN).
module axi4_lite_regfile_slave
    import axil_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic [ADDR_W-1:0]          AWADDR,
    input  logic                       AWVALID,
    output logic                       AWREADY,
    input  logic [DATA_W-1:0]          WDATA,
    input  logic [DATA_W/8-1:0]        WSTRB,
    input  logic                       WVALID,
    output logic                       WREADY,
    output logic [1:0]                 BRESP,
    output logic                       BVALID,
    input  logic                       BREADY,
    input  logic [ADDR_W-1:0]          ARADDR,
    input  logic                       ARVALID,
    output logic                       ARREADY,
    output logic [DATA_W-1:0]          RDATA,
    output logic [1:0]                 RRESP,
    output logic                       RVALID,
    input  logic                       RREADY,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]        wr_pulse
);
    localparam int OFF   = $clog2(DATA_W/8);
    localparam int IDX_W = ADDR_W - OFF;

    wr_state_t                          ws_q, ws_d;
    rd_state_t                          rs_q, rs_d;
    logic                               aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic                               awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic                               bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    resp_t                              bresp_q, bresp_d, rresp_q, rresp_d;
    logic [IDX_W-1:0]                   widx_q, widx_d;
    logic [DATA_W-1:0]                  wdata_q, wdata_d, rdata_q, rdata_d, old_word, merged;
    logic [DATA_W/8-1:0]                wstrb_q, wstrb_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]    regs_q, regs_d;
    logic [NUM_REGS-1:0]                pulse_q, pulse_d;
    logic [IDX_W-1:0]                   ridx;
    logic                               aw_hs, w_hs, w_ok, r_ok, unused_lo;

    assign aw_hs     = AWVALID && awready_q;
    assign w_hs      = WVALID && wready_q;
    assign ridx      = ARADDR[ADDR_W-1:OFF];
    assign w_ok      = {1'b0, widx_q} < (IDX_W+1)'(NUM_REGS);
    assign r_ok      = {1'b0, ridx} < (IDX_W+1)'(NUM_REGS);
    assign unused_lo = ^{AWADDR[OFF-1:0], ARADDR[OFF-1:0]};

    always_comb begin
        old_word = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (widx_q == IDX_W'(i)) old_word = regs_q[i];
    end

    axil_wstrb_merge #(.DATA_W(DATA_W)) u_merge (
        .old_i(old_word), .new_i(wdata_q), .strb_i(wstrb_q), .merged_o(merged)
    );

    // Commit happens the cycle after both halves are held, so READYs stay registered.
    always_comb begin
        ws_d      = ws_q;
        aw_held_d = aw_held_q | aw_hs;
        w_held_d  = w_held_q | w_hs;
        widx_d    = aw_hs ? AWADDR[ADDR_W-1:OFF] : widx_q;
        wdata_d   = w_hs ? WDATA : wdata_q;
        wstrb_d   = w_hs ? WSTRB : wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        pulse_d   = '0;
        if (ws_q == W_IDLE && aw_held_q && w_held_q) begin
            ws_d     = W_RESP;
            bvalid_d = 1'b1;
            bresp_d  = w_ok ? OKAY : DECERR;
            for (int i = 0; i < NUM_REGS; i++)
                if (widx_q == IDX_W'(i)) begin
                    regs_d[i]  = merged;
                    pulse_d[i] = 1'b1;
                end
        end else if (ws_q == W_RESP && BREADY) begin
            ws_d      = W_IDLE;
            bvalid_d  = 1'b0;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end
        awready_d = ws_d == W_IDLE && !aw_held_d;
        wready_d  = ws_d == W_IDLE && !w_held_d;
    end

    always_comb begin
        rs_d     = rs_q;
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (rs_q == R_IDLE && ARVALID && arready_q) begin
            rs_d     = R_DATA;
            rvalid_d = 1'b1;
            rresp_d  = r_ok ? OKAY : DECERR;
            rdata_d  = '0;
            for (int i = 0; i < NUM_REGS; i++)
                if (ridx == IDX_W'(i)) rdata_d = regs_q[i];
        end else if (rs_q == R_DATA && RREADY) begin
            rs_d     = R_IDLE;
            rvalid_d = 1'b0;
        end
        arready_d = rs_d == R_IDLE;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ws_q      <= W_IDLE;
            rs_q      <= R_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            rresp_q   <= OKAY;
            widx_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            regs_q    <= '0;
            pulse_q   <= '0;
        end else begin
            ws_q      <= ws_d;
            rs_q      <= rs_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            widx_q    <= widx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            regs_q    <= regs_d;
            pulse_q   <= pulse_d;
        end
    end

    assign AWREADY  = awready_q;
    assign WREADY   = wready_q;
    assign ARREADY  = arready_q;
    assign BVALID   = bvalid_q;
    assign BRESP    = bresp_q;
    assign RVALID   = rvalid_q;
    assign RRESP    = rresp_q;
    assign RDATA    = rdata_q;
    assign reg_q    = regs_q;
    assign wr_pulse = pulse_q;
endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// tb_axi4_lite_regfile_slave: directed scoreboard bench for the AXI4-Lite register file;
// expected strobe behaviour follows AXIL_REGFILE_WSTRB_EN.
module tb_axi4_lite_regfile_slave;
    localparam int AW = 8, DW = 32, NR = 4;

    logic              ACLK = 1'b0, ARESETn = 1'b0;
    logic [AW-1:0]     AWADDR = '0, ARADDR = '0;
    logic              AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
    logic [DW-1:0]     WDATA = '0;
    logic [DW/8-1:0]   WSTRB = '0;
    logic              AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]        BRESP, RRESP;
    logic [DW-1:0]     RDATA;
    logic [NR*DW-1:0]  reg_q;
    logic [NR-1:0]     wr_pulse;

    axi4_lite_regfile_slave #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .reg_q(reg_q), .wr_pulse(wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0, errors = 0;
    logic [1:0]               exp_b_q[$];
    logic [33:0]              exp_r_q[$];
    logic [NR-1:0][DW-1:0]    model = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [3:0] strb, input int lead);
        int idx = int'(addr[AW-1:2]);
        bit ok = idx < NR;
        bit aw_done = 0, w_done = 0, aw_go, w_go;
        int t = 0;
        if (ok) begin
`ifdef AXIL_REGFILE_WSTRB_EN
            for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
`else
            model[idx] = data;
`endif
        end
        exp_b_q.push_back(ok ? 2'b00 : 2'b11);
        while (!(aw_done && w_done)) begin
            if (t > 40) begin
                chk("wr_handshake_timeout", 0, 1);
                break;
            end
            if (!aw_done && t >= (lead > 0 ? lead : 0)) begin AWVALID = 1; AWADDR = addr; end
            if (!w_done && t >= (lead < 0 ? -lead : 0)) begin WVALID = 1; WDATA = data; WSTRB = strb; end
            if (w_done && !aw_done) chk("wready_held_low", WREADY, 0);
            if (aw_done && !w_done) chk("awready_held_low", AWREADY, 0);
            aw_go = AWVALID && AWREADY;
            w_go  = WVALID && WREADY;
            @(negedge ACLK);
            t++;
            if (aw_go) begin aw_done = 1; AWVALID = 0; end
            if (w_go)  begin w_done = 1;  WVALID = 0;  end
        end
        chk("bvalid_not_early", BVALID, 0);
        @(negedge ACLK);
        chk("bvalid", BVALID, 1);
        chk("bresp", BRESP, exp_b_q.pop_front());
        chk("wr_pulse", wr_pulse, ok ? (4'b1 << idx) : 4'b0);
        chk("reg_q", reg_q, model);
        BREADY = 1;
        @(negedge ACLK);
        BREADY = 0;
        chk("bvalid_clear", BVALID, 0);
        chk("wr_pulse_one_cycle", wr_pulse, 0);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int hold);
        int idx = int'(addr[AW-1:2]);
        int t = 0;
        logic [DW-1:0] snap;
        logic [33:0] exp;
        exp_r_q.push_back(idx < NR ? {2'b00, model[idx]} : {2'b11, 32'h0});
        ARVALID = 1;
        ARADDR = addr;
        while (!ARREADY && t < 40) begin @(negedge ACLK); t++; end
        @(negedge ACLK);
        ARVALID = 0;
        t = 0;
        while (!RVALID && t < 20) begin @(negedge ACLK); t++; end
        chk("rvalid", RVALID, 1);
        snap = RDATA;
        for (int k = 0; k < hold; k++) begin
            chk("arready_low_while_pending", ARREADY, 0);
            chk("rdata_stable", RDATA, snap);
            chk("rvalid_held", RVALID, 1);
            @(negedge ACLK);
        end
        exp = exp_r_q.pop_front();
        chk("rdata", RDATA, exp[31:0]);
        chk("rresp", RRESP, exp[33:32]);
        RREADY = 1;
        @(negedge ACLK);
        RREADY = 0;
        chk("rvalid_clear", RVALID, 0);
    endtask

    initial begin
        repeat (2) @(negedge ACLK);
        chk("rst_awready", AWREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_arready", ARREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_resp", {BRESP, RRESP}, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_reg_q", reg_q, 0);
        chk("rst_wr_pulse", wr_pulse, 0);
        ARESETn = 1;
        @(negedge ACLK);
        chk("readies_up", {AWREADY, WREADY, ARREADY}, 3'b111);

        do_write(8'h00, 32'h0000_0001, 4'hF, 0);
        do_write(8'h04, 32'hA5A5_A5A5, 4'hF, 3);
        do_write(8'h08, 32'h1122_3344, 4'hF, -2);
        do_write(8'h08, 32'hFFFF_FFFF, 4'b0101, 0);
        do_write(8'h10, 32'hDEAD_BEEF, 4'hF, 0);
        do_write(8'h0F, 32'h5555_AAAA, 4'hF, 1);
        do_read(8'h10, 0);
        do_read(8'h00, 0);
        do_read(8'h05, 1);
        do_read(8'h08, 0);
        do_read(8'h0C, 5);

        AWVALID = 1; AWADDR = 8'h04; WVALID = 1; WDATA = 32'h0BAD_F00D; WSTRB = 4'hF;
        @(negedge ACLK);
        AWVALID = 0; WVALID = 0;
        @(negedge ACLK);
        chk("pre_reset_bvalid", BVALID, 1);
        ARESETn = 0;
        #1;
        chk("mid_reset_bvalid", BVALID, 0);
        chk("mid_reset_reg_q", reg_q, 0);
        chk("mid_reset_readies", {AWREADY, WREADY, ARREADY}, 0);
        chk("mid_reset_wr_pulse", wr_pulse, 0);
        model = '0;
        @(negedge ACLK);
        ARESETn = 1;
        chk("readies_low_at_release", {AWREADY, WREADY, ARREADY}, 0);
        @(negedge ACLK);
        chk("readies_back", {AWREADY, WREADY, ARREADY}, 3'b111);
        chk("no_resp_after_reset", BVALID, 0);
        do_read(8'h04, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
